cla_serial_subtractor: RTL and testbench

//  Multi-cycle WIDTH-bit subtractor: computes diff = a - b - bin, one 4-bit carry-lookahead

---
 rtl/cla_sub_pkg.sv | 17 +
 rtl/cla4_sub_slice.sv | 30 +++
 rtl/cla_serial_subtractor.sv | 150 +++++++++++++++
 tb/tb_cla_serial_subtractor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_sub_pkg.sv
// Shared types and helpers for the nibble-serial CLA subtractor.
// Used by cla4_sub_slice and cla_serial_subtractor.
package cla_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int nib_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla4_sub_slice.sv
// Combinational 4-bit carry-lookahead slice computing a4 + ~b4 + cin.
// All carries come directly from p/g and cin in lookahead form, not rippled.
module cla4_sub_slice
  import cla_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               cin,
  output logic [SLICE_W-1:0] s4,
  output logic               cout
);

  logic [SLICE_W-1:0] bn;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic               c1, c2, c3;

  assign bn = ~b4;
  assign p  = a4 ^ bn;
  assign g  = a4 & bn;

  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s4 = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (diff = a - b - bin), one CLA nibble per clock, LSB first.
// Optional zero/ovf flag outputs are enabled by defining CLA_SUB_FLAGS_EN.
module cla_serial_subtractor
  import cla_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CLA_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int NIB = nib_count(WIDTH);
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
`ifdef CLA_SUB_FLAGS_EN
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
`endif

  logic [SLICE_W-1:0] a4, b4, s4;
  logic               c4;
  logic               last;

  // Operand nibble mux selected by the slice counter
  always_comb begin
    a4 = '0;
    b4 = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        a4 = a_q[i*SLICE_W +: SLICE_W];
        b4 = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  cla4_sub_slice u_slice (
    .a4   (a4),
    .b4   (b4),
    .cin  (carry_q),
    .s4   (s4),
    .cout (c4)
  );

  assign last = (cnt_q == CW'(NIB - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef CLA_SUB_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ~bin;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) diff_d[i*SLICE_W +: SLICE_W] = s4;
        end
        carry_d = c4;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          // Carry-out of a + ~b + ~bin is the inverse of the borrow
          bout_d  = ~c4;
          cnt_d   = '0;
          state_d = DONE;
`ifdef CLA_SUB_FLAGS_EN
          zero_d  = (diff_d == '0);
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s4[SLICE_W-1] != a_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef CLA_SUB_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef CLA_SUB_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef CLA_SUB_FLAGS_EN
  assign zero      = zero_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Directed and randomized self-checking bench for cla_serial_subtractor (WIDTH=16).
// Flag checks are compiled in when CLA_SUB_FLAGS_EN is defined.
module tb_cla_serial_subtractor;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef CLA_SUB_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int pass_cnt;
  int total_cnt;

  cla_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef CLA_SUB_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands, wait for out_valid (bounded), hold out_ready low for hold_cycles,
  // then capture the result and complete the output handshake.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input int hold_cycles, output logic [W-1:0] d, output logic bo,
                        output logic zf, output logic of, output int lat);
    @(posedge clk); #1;
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    while (!in_ready) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < hold_cycles; i++) begin @(posedge clk); #1; end
    d = diff; bo = bout;
`ifdef CLA_SUB_FLAGS_EN
    zf = zero; of = ovf;
`else
    zf = 1'b0; of = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #23;
    total_cnt++;
    if ({in_ready, out_valid, diff, bout} !== {1'b1, 1'b0, 16'h0000, 1'b0})
      $display("FAIL reset: in_ready=%b out_valid=%b diff=%h bout=%b, want 1 0 0000 0",
               in_ready, out_valid, diff, bout);
    else pass_cnt++;
    rst = 1'b0;
    $display("reset: in_ready=%b out_valid=%b diff=%h bout=%b", in_ready, out_valid, diff, bout);
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5] = '{16'h1234, 16'h0000, 16'h0005, 16'h0005, 16'hA5A5};
    logic [W-1:0] vb [5] = '{16'h0034, 16'h0001, 16'h0005, 16'h0005, 16'h5A5A};
    logic         vi [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] vd [5] = '{16'h1200, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h4B4A};
    logic         vo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] d;
    logic         bo, zf, of;
    int           lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vi[i], 0, d, bo, zf, of, lat);
      $display("directed %0d: a=%h b=%h bin=%b -> diff=%h bout=%b lat=%0d",
               i, va[i], vb[i], vi[i], d, bo, lat);
      total_cnt++;
      if (d !== vd[i] || bo !== vo[i])
        $display("FAIL directed_%0d: diff=%h bout=%b, want diff=%h bout=%b", i, d, bo, vd[i], vo[i]);
      else pass_cnt++;
      total_cnt++;
      if (lat !== 4) $display("FAIL latency_%0d: got %0d cycles, want 4", i, lat);
      else pass_cnt++;
    end
  endtask

`ifdef CLA_SUB_FLAGS_EN
  task automatic test_flags();
    logic [W-1:0] va [3] = '{16'h8000, 16'h7FFF, 16'h0005};
    logic [W-1:0] vb [3] = '{16'h0001, 16'h0001, 16'h0005};
    logic [W-1:0] vd [3] = '{16'h7FFF, 16'h7FFE, 16'h0000};
    logic         vz [3] = '{1'b0, 1'b0, 1'b1};
    logic         vf [3] = '{1'b1, 1'b0, 1'b0};
    logic [W-1:0] d;
    logic         bo, zf, of;
    int           lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b0, 0, d, bo, zf, of, lat);
      $display("flags %0d: a=%h b=%h -> diff=%h zero=%b ovf=%b", i, va[i], vb[i], d, zf, of);
      total_cnt++;
      if (d !== vd[i] || zf !== vz[i] || of !== vf[i])
        $display("FAIL flags_%0d: diff=%h zero=%b ovf=%b, want diff=%h zero=%b ovf=%b",
                 i, d, zf, of, vd[i], vz[i], vf[i]);
      else pass_cnt++;
    end
  endtask
`endif

  task automatic test_backpressure();
    int lat;
    logic ok;
    @(posedge clk); #1;
    a = 16'h0100; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 16'hFFFF; b = 16'h1111; in_valid = 1'b1;
      if (diff !== 16'h00FF || bout !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        ok = 1'b0;
        $display("FAIL backpressure_hold cycle %0d: diff=%h bout=%b in_ready=%b out_valid=%b, want 00ff 0 0 1",
                 i, diff, bout, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    total_cnt++;
    if (ok) pass_cnt++;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h00FF)
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b diff=%h, want 1 0 00ff",
               in_ready, out_valid, diff);
    else pass_cnt++;
    $display("backpressure: released, in_ready=%b out_valid=%b diff=%h", in_ready, out_valid, diff);
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] d;
    logic         bo, zf, of;
    int           lat;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total_cnt++;
    if (diff !== 16'h00EE || out_valid !== 1'b0)
      $display("FAIL partial_diff: diff=%h out_valid=%b, want 00ee 0", diff, out_valid);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || diff !== 16'h0000 || in_ready !== 1'b1 || bout !== 1'b0)
      $display("FAIL mid_reset: out_valid=%b diff=%h in_ready=%b bout=%b, want 0 0000 1 0",
               out_valid, diff, in_ready, bout);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    run_op(16'h4321, 16'h1234, 1'b1, 0, d, bo, zf, of, lat);
    $display("mid_reset follow-up: diff=%h bout=%b", d, bo);
    total_cnt++;
    if (d !== 16'h30EC || bo !== 1'b0)
      $display("FAIL after_reset_op: diff=%h bout=%b, want 30ec 0", d, bo);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, d;
    logic         bi, bo, zf, of;
    logic [W:0]   exp;
    int           lat;
    for (int n = 0; n < 1000; n++) begin
      av = W'($urandom); bv = W'($urandom); bi = 1'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(posedge clk);
      run_op(av, bv, bi, int'($urandom_range(0, 3)), d, bo, zf, of, lat);
      exp = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
      $display("random %0d: a=%h b=%h bin=%b -> diff=%h bout=%b", n, av, bv, bi, d, bo);
      total_cnt++;
      if (d !== exp[W-1:0] || bo !== exp[W])
        $display("FAIL random_%0d: diff=%h bout=%b, want diff=%h bout=%b", n, d, bo, exp[W-1:0], exp[W]);
      else pass_cnt++;
`ifdef CLA_SUB_FLAGS_EN
      total_cnt++;
      if (zf !== (exp[W-1:0] == '0) || of !== ((av[W-1] != bv[W-1]) && (exp[W-1] != av[W-1])))
        $display("FAIL random_flags_%0d: zero=%b ovf=%b", n, zf, of);
      else pass_cnt++;
`endif
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_directed();
`ifdef CLA_SUB_FLAGS_EN
    test_flags();
`endif
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
